// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states, decision encoding
// and the decision-to-G/E/L mapping.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_GT = 2'd1,
    CMP_LT = 2'd2
  } cmp_e;

  // {G, E, L} seen while idle after reset and right after an accepted start.
  localparam logic [2:0] GelReset = 3'b010;

  function automatic logic [2:0] cmp_to_gel(cmp_e c);
    case (c)
      CMP_GT:  return 3'b100;
      CMP_LT:  return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Handshake and result bundle between a serial bit source and the magnitude comparator.
interface serial_magnitude_comparator_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
);

  logic             start;
  logic             bit_valid;
  logic             a_bit;
  logic             b_bit;
  logic             busy;
  logic             done;
  logic             G;
  logic             E;
  logic             L;
  logic [CNT_W-1:0] bits_seen;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  busy, done, G, E, L, bits_seen
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output busy, done, G, E, L, bits_seen
  );

endinterface

// File: rtl/bit_cmp_cell.sv
// Next-decision logic for one accepted bit pair. Bit order is MSB first by default;
// defining SERIAL_CMP_LSB_FIRST_EN selects LSB-first (last difference wins).
module bit_cmp_cell
  import serial_cmp_pkg::*;
(
  input  cmp_e cur_i,
  input  logic a_bit_i,
  input  logic b_bit_i,
  output cmp_e nxt_o
);

  cmp_e diff;

  always_comb begin
    diff = a_bit_i ? CMP_GT : CMP_LT;
    nxt_o = cur_i;
`ifdef SERIAL_CMP_LSB_FIRST_EN
    // Higher-order bits arrive later, so any later difference overrides earlier ones.
    if (a_bit_i != b_bit_i) begin
      nxt_o = diff;
    end
`else
    // The first difference seen MSB-first decides the result for good.
    if ((cur_i == CMP_EQ) && (a_bit_i != b_bit_i)) begin
      nxt_o = diff;
    end
`endif
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: FSM, bit counter and registered G/E/L result.
// Optional build macro SERIAL_CMP_LSB_FIRST_EN switches operand order to LSB first.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic                          clk,
  input logic                          rst_n,
  serial_magnitude_comparator_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  cmp_e             cmp_q, cmp_d, cmp_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       gel_q, gel_d;
  logic             cnt_full;

  assign cnt_full = (cnt_q == CNT_W'(WIDTH));

  bit_cmp_cell u_bit_cmp_cell (
    .cur_i   (cmp_q),
    .a_bit_i (bus.a_bit),
    .b_bit_i (bus.b_bit),
    .nxt_o   (cmp_next)
  );

  always_comb begin
    state_d = state_q;
    cmp_d   = cmp_q;
    cnt_d   = cnt_q;
    gel_d   = gel_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          cmp_d   = CMP_EQ;
          cnt_d   = '0;
          gel_d   = GelReset;
        end
      end
      SHIFT: begin
        // One settle cycle after the last pair keeps done exactly WIDTH+1 cycles after start.
        if (cnt_full) begin
          state_d = DONE;
          gel_d   = cmp_to_gel(cmp_q);
        end else if (bus.bit_valid) begin
          cmp_d = cmp_next;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmp_q   <= CMP_EQ;
      cnt_q   <= '0;
      gel_q   <= GelReset;
    end else begin
      state_q <= state_d;
      cmp_q   <= cmp_d;
      cnt_q   <= cnt_d;
      gel_q   <= gel_d;
    end
  end

  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = (state_q == DONE);
  assign bus.G         = gel_q[2];
  assign bus.E         = gel_q[1];
  assign bus.L         = gel_q[0];
  assign bus.bits_seen = cnt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed and random checks of serial_magnitude_comparator (WIDTH=4), in either bit order.
module tb_serial_magnitude_comparator;

  localparam int unsigned W = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  serial_magnitude_comparator_if #(.WIDTH(W)) bus ();

  serial_magnitude_comparator #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Maps an operand to the order its bits go on the wire (index W-1 is sent first).
  function automatic logic [W-1:0] to_stream(input logic [W-1:0] x);
    logic [W-1:0] r;
`ifdef SERIAL_CMP_LSB_FIRST_EN
    for (int i = 0; i < int'(W); i++) r[i] = x[int'(W) - 1 - i];
`else
    r = x;
`endif
    return r;
  endfunction

  function automatic logic [2:0] ref_gel(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a > b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge after the done cycle.
  task automatic do_cmp(input string tag, input logic [W-1:0] a_s, input logic [W-1:0] b_s,
                        input int stall_at, input int stall_n, input logic [2:0] exp_gel,
                        input int exp_lat, input bit hold_start);
    int lat;
    int idx;
    int stalled;
    bit seen;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
    check_eq({tag, "_gel_cleared"}, 32'({bus.G, bus.E, bus.L}), 32'(3'b010));
    check_eq({tag, "_bits_cleared"}, 32'(bus.bits_seen), 32'd0);
    lat = 0;
    idx = 0;
    stalled = 0;
    seen = 1'b0;
    while (lat < 60) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (idx < int'(W)) begin
        if (idx == stall_at && stalled < stall_n) begin
          bus.bit_valid = 1'b0;
          bus.a_bit = 1'b1;
          bus.b_bit = 1'b0;
          stalled++;
        end else begin
          bus.bit_valid = 1'b1;
          bus.a_bit = a_s[int'(W) - 1 - idx];
          bus.b_bit = b_s[int'(W) - 1 - idx];
          idx++;
        end
      end else begin
        bus.bit_valid = 1'b0;
        bus.a_bit = 1'b1;
        bus.b_bit = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.bit_valid = 1'b0;
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_gel"}, 32'({bus.G, bus.E, bus.L}), 32'(exp_gel));
    check_eq({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_bits_seen"}, 32'(bus.bits_seen), 32'(W));
    bus.start = hold_start;
    @(negedge clk);
    check_eq({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    check_eq({tag, "_idle_not_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_gel_held"}, 32'({bus.G, bus.E, bus.L}), 32'(exp_gel));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int done_cnt;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.bit_valid = 1'b0;
    bus.a_bit = 1'b0;
    bus.b_bit = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_gel", 32'({bus.G, bus.E, bus.L}), 32'(3'b010));
    check_eq("rst_bits", 32'(bus.bits_seen), 32'd0);

    do_cmp("gt", to_stream(4'b1010), to_stream(4'b0111), -1, 0, 3'b100, 5, 1'b0);
    do_cmp("eq_stall", to_stream(4'b0101), to_stream(4'b0101), 2, 2, 3'b010, 7, 1'b0);
    // start held through the DONE cycle is ignored there, then taken in IDLE.
    do_cmp("lt", to_stream(4'b0011), to_stream(4'b1000), -1, 0, 3'b001, 5, 1'b1);
    do_cmp("back2back", to_stream(4'b1100), to_stream(4'b1011), -1, 0, 3'b100, 5, 1'b0);

    // Mid-comparison reset discards the partial result.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) begin
      bus.bit_valid = 1'b1;
      bus.a_bit = 1'b1;
      bus.b_bit = 1'b0;
      @(negedge clk);
    end
    check_eq("mid_bits", 32'(bus.bits_seen), 32'd2);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("async_rst_gel", 32'({bus.G, bus.E, bus.L}), 32'(3'b010));
    check_eq("async_rst_bits", 32'(bus.bits_seen), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    bus.bit_valid = 1'b0;
    check_eq("rst_no_done", 32'(done_cnt), 32'd0);
    check_eq("idle_ignores_bits", 32'(bus.bits_seen), 32'd0);
    check_eq("post_rst_gel", 32'({bus.G, bus.E, bus.L}), 32'(3'b010));
    do_cmp("zero_eq", 4'b0000, 4'b0000, -1, 0, 3'b010, 5, 1'b0);

    // Wire stream of A=0110, B=0101 sent LSB first.
`ifdef SERIAL_CMP_LSB_FIRST_EN
    do_cmp("order", 4'b0110, 4'b1010, -1, 0, 3'b100, 5, 1'b0);
`else
    do_cmp("order", 4'b0110, 4'b1010, -1, 0, 3'b001, 5, 1'b0);
`endif

    for (int i = 0; i < 15; i++) begin
      ra = W'($random);
      rb = W'($random);
      do_cmp($sformatf("rand%0d_%h_%h", i, ra, rb), to_stream(ra), to_stream(rb),
             (i % 3 == 0) ? 1 : -1, 1, ref_gel(ra, rb), (i % 3 == 0) ? 6 : 5, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Bit-serial counterpart of the team's four-bit parallel comparator.
- Receives operands A and B one bit pair per clock, MSB first, from a shift-register or serial link.
- After WIDTH accepted bit pairs, presents registered G/E/L flags with a one-cycle done pulse.
- Used where operands arrive serially and a full parallel comparator is not wanted.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..16).
- CNT_W, $clog2(WIDTH+1), width of the bit counter (derived; do not override).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new comparison; sampled only when busy=0.
- bit_valid  input  1  a_bit/b_bit carry a valid bit pair this cycle.
- a_bit  input  1  current bit of operand A.
- b_bit  input  1  current bit of operand B.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the result becomes valid.
- G  output  1  A > B (held until the next start).
- E  output  1  A == B (held until the next start).
- L  output  1  A < B (held until the next start).
- bits_seen  output  CNT_W  number of bit pairs accepted in the current comparison.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, G=0, E=1, L=0, bits_seen=0.
  - Takes effect immediately, including mid-comparison; a partial comparison is discarded with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: start=1 → SHIFT. Clears the decision to EQ and bits_seen to 0. G/E/L switch to 0/1/0 on that edge. busy=1 from the next cycle.
  - SHIFT: each cycle with bit_valid=1 accepts one bit pair and increments bits_seen.
    - Decision is EQ: a_bit>b_bit → GT; a_bit<b_bit → LT; equal bits → stay EQ.
    - Decision is already GT or LT: it is locked for the rest of the operand (MSB-first).
    - bit_valid=0: stall; no state change, no count change.
    - When the WIDTH-th pair is accepted → DONE.
  - DONE: lasts exactly one cycle. done=1, busy=0, G/E/L reflect the final decision. Next state is IDLE.
- Exactly one of G/E/L is high at all times outside reset.
- Latency: done asserts exactly 1 cycle after the clock edge that accepts the last bit pair. With no stalls, done is WIDTH+1 cycles after the start edge.
- Inputs ignored while busy: start is ignored in SHIFT. start in the DONE cycle is also ignored; a new start is accepted only in IDLE.
- bit_valid outside SHIFT is ignored.
- bits_seen saturates at WIDTH and holds its value until the next accepted start.

Optional Feature:
- Macro SERIAL_CMP_LSB_FIRST_EN.
- Defined: operands arrive LSB first. Every unequal bit pair overwrites the decision (the last difference wins). Equal bit pairs keep the current decision.
- Not defined: MSB-first with lock-on-first-difference, as above.
- Ports, latency and handshake are identical in both builds.

Decomposition:
- Shared package serial_cmp_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - result enum (CMP_EQ, CMP_GT, CMP_LT) plus the mapping to G/E/L.
- One sub-module, bit_cmp_cell: combinational next-decision logic. Inputs are the current decision, a_bit and b_bit; output is the next decision. It contains the MSB/LSB-order logic selected by the macro.
- The top module holds the FSM, counter and output registers.

Test Plan:
- Reset check: rst_n low, then release → busy=0, done=0, G/E/L=0/1/0, bits_seen=0.
- A=1010, B=0111, MSB-first, no stalls → done on cycle 5 after start, G=1 E=0 L=0, bits_seen=4.
- A=0101, B=0101, with bit_valid low for 2 cycles after bit 2 → done 7 cycles after start, E=1, no early done.
- A=0011, B=1000 → L=1. Then a second start immediately after done → flags return to 0/1/0 and the new comparison runs correctly.
- rst_n pulsed low after 2 bits of A=1111, B=0000 → no done pulse, outputs at reset values. A following full compare of 0000 vs 0000 → E=1.
- Build with SERIAL_CMP_LSB_FIRST_EN, A=0110, B=0101 sent LSB first → G=1. The same bit stream in the default build → L=1.
- Random sweep: 15 random A/B pairs checked against a reference model ($random, matching the team's parallel comparator bench).
